reg_bank_arbiter: RTL and testbench



---
 rtl/reg_bank_arbiter.sv | 102 ++++++++++
 tb/tb_reg_bank_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbitration of one shared write port
// onto a DEPTH x WIDTH flip-flop register bank.

module reg_bank_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

endmodule

module reg_bank_arbiter #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  data_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  data_b,
    output logic              gnt_b,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              last_gnt,
    output logic              conflict,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic                         prio;
    logic                         any_gnt;
    logic [ADDR_W-1:0]            wr_addr;
    logic [WIDTH-1:0]             wr_data;
    logic [DEPTH-1:0][WIDTH-1:0]  bank_q;
    logic [DEPTH-1:0][WIDTH-1:0]  bank_d;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                (req_a && req_b): begin
                    gnt_a = ~prio;
                    gnt_b = prio;
                end
                (req_a && !req_b): gnt_a = 1'b1;
                (!req_a && req_b): gnt_b = 1'b1;
                default: ;
            endcase
        end
    end

    assign any_gnt = gnt_a | gnt_b;
    assign wr_addr = gnt_b ? addr_b : addr_a;
    assign wr_data = gnt_b ? data_b : data_a;

    // Plain D cells: the write enable is folded into the D-input mux.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        assign bank_d[r] =
            (any_gnt && wr_addr == ADDR_W'(r))
            ? wr_data : bank_q[r];
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            reg_bank_dff u_dff (
                .clk (clk),
                .rst (rst),
                .d   (bank_d[r][b]),
                .q   (bank_q[r][b])
            );
        end
    end

    assign rd_data = bank_q[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio     <= 1'b0;
            last_gnt <= 1'b0;
            conflict <= 1'b0;
            wr_count <= '0;
        end else begin
            conflict <= req_a & req_b;
            if (any_gnt) begin
                prio     <= gnt_a;
                last_gnt <= gnt_b;
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: stimulus queues
// expectations per cycle, a negedge monitor checks them.

module tb_reg_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic [1:0] addr_a = '0;
    logic [3:0] data_a = '0;
    logic       gnt_a;
    logic       req_b = 1'b0;
    logic [1:0] addr_b = '0;
    logic [3:0] data_b = '0;
    logic       gnt_b;
    logic [1:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic       last_gnt;
    logic       conflict;
    logic [7:0] wr_count;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    localparam int S_GA = 0, S_GB = 1, S_RD = 2;
    localparam int S_LG = 3, S_CF = 4, S_WC = 5;

    reg_bank_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .addr_a   (addr_a),
        .data_a   (data_a),
        .gnt_a    (gnt_a),
        .req_b    (req_b),
        .addr_b   (addr_b),
        .data_b   (data_b),
        .gnt_b    (gnt_b),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .last_gnt (last_gnt),
        .conflict (conflict),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_GA:    return {31'd0, gnt_a};
            S_GB:    return {31'd0, gnt_b};
            S_RD:    return {28'd0, rd_data};
            S_LG:    return {31'd0, last_gnt};
            S_CF:    return {31'd0, conflict};
            default: return {24'd0, wr_count};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = observe(e.sel);
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: stale entry cyc %0d at %0d",
                         e.nm, e.cyc, cyc);
            end else if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                         e.nm, act, e.v, cyc);
            end
        end
    end

    task automatic expect_v(int sel, logic [31:0] v, string nm);
        exp_t e;
        e.cyc = cyc;
        e.sel = sel;
        e.v   = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic ra, logic [1:0] aa, logic [3:0] da,
                         logic rb, logic [1:0] ab, logic [3:0] db,
                         logic [1:0] ra_rd);
        req_a = ra; addr_a = aa; data_a = da;
        req_b = rb; addr_b = ab; data_b = db;
        rd_addr = ra_rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // initial reset with A requesting
        drive(1, 0, 4'h7, 0, 0, 0, 0);
        tick();
        expect_v(S_GA, 0, "rst_gnt_a");
        expect_v(S_GB, 0, "rst_gnt_b");
        expect_v(S_WC, 0, "rst_wr_count");
        expect_v(S_LG, 0, "rst_last_gnt");
        expect_v(S_CF, 0, "rst_conflict");
        expect_v(S_RD, 0, "rst_rd0");
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // single writer
        drive(1, 2, 4'hA, 0, 0, 0, 2);
        expect_v(S_GA, 1, "single_gnt_a");
        expect_v(S_GB, 0, "single_gnt_b");
        expect_v(S_RD, 0, "single_rd_old");
        tick();
        drive(0, 0, 0, 0, 0, 0, 2);
        expect_v(S_RD, 4'hA, "single_rd_new");
        expect_v(S_WC, 1, "single_wr_count");
        expect_v(S_LG, 0, "single_last_gnt");
        expect_v(S_CF, 0, "single_conflict");
        tick();

        // asynchronous reset mid-run, A requesting
        drive(1, 1, 4'h9, 0, 0, 0, 2);
        rst = 1'b1;
        expect_v(S_GA, 0, "midrst_gnt_a");
        expect_v(S_RD, 0, "midrst_rd2");
        expect_v(S_WC, 0, "midrst_wr_count");
        expect_v(S_LG, 0, "midrst_last_gnt");
        tick();
        rst = 1'b0;

        // contention round-robin from reset
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 4'h1, 1, 1, 4'h2, 0);
            expect_v(S_GA, (i % 2 == 0), "rr_gnt_a");
            expect_v(S_GB, (i % 2 == 1), "rr_gnt_b");
            expect_v(S_CF, (i != 0), "rr_conflict");
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_v(S_WC, 4, "rr_wr_count");
        expect_v(S_LG, 1, "rr_last_gnt");
        expect_v(S_CF, 1, "rr_conflict_tail");
        expect_v(S_RD, 1, "rr_bank0");
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        expect_v(S_CF, 0, "rr_conflict_clear");
        expect_v(S_RD, 2, "rr_bank1");
        tick();

        // same-address collision, prio back at A
        drive(1, 3, 4'h5, 1, 3, 4'h6, 3);
        expect_v(S_GA, 1, "coll_gnt_a");
        expect_v(S_RD, 0, "coll_rd_old");
        tick();
        drive(0, 0, 0, 1, 3, 4'h6, 3);
        expect_v(S_GB, 1, "coll_gnt_b");
        expect_v(S_RD, 5, "coll_rd_a");
        tick();
        drive(0, 0, 0, 0, 0, 0, 3);
        expect_v(S_RD, 6, "coll_rd_final");
        expect_v(S_WC, 6, "coll_wr_count");
        tick();

        // read during write, no bypass
        drive(1, 1, 4'h3, 0, 0, 0, 1);
        expect_v(S_GA, 1, "rdw_prep_gnt");
        tick();
        drive(0, 0, 0, 1, 1, 4'hC, 1);
        expect_v(S_GB, 1, "rdw_gnt_b");
        expect_v(S_RD, 3, "rdw_rd_old");
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        expect_v(S_RD, 4'hC, "rdw_rd_new");
        expect_v(S_LG, 1, "rdw_last_gnt");
        expect_v(S_WC, 8, "rdw_wr_count");
        tick();

        // counter wrap after 256 writes from reset
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1, 2'(i), 4'(i), 0, 0, 0, 0);
            expect_v(S_GA, 1, "wrap_gnt_a");
            if (i == 255) expect_v(S_WC, 255, "wrap_max");
            tick();
        end
        drive(1, 0, 4'h0, 1, 1, 4'h4, 3);
        expect_v(S_WC, 0, "wrap_zero");
        expect_v(S_LG, 0, "wrap_last_gnt");
        expect_v(S_RD, 4'hF, "wrap_bank3");
        expect_v(S_GB, 1, "wrap_prio_b");
        expect_v(S_GA, 0, "wrap_prio_not_a");
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        if (sb.size() != 0) begin
            errors += sb.size();
            checks += sb.size();
            $display("FAIL scoreboard_drain: %0d left, need 0",
                     sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
